// File: rtl/cp0_ctrl.sv
// Coprocessor-0 / interrupt controller: STATUS, CAUSE, EPC, EHBASE, one synchronised
// external interrupt, and ERET/interrupt PC redirection for the ID stage.
module cp0_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100,
    parameter int unsigned HOLDOFF      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  oper,
    input  logic [4:0]  addr_r,
    output logic [31:0] data_r,
    input  logic [4:0]  addr_w,
    input  logic [31:0] data_w,
    input  logic        ir_en,
    input  logic [31:0] ret_addr,
    input  logic        ir_in,
    output logic        jump_en,
    output logic [31:0] jump_addr
);

    localparam int CNT_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] OPER_MTC0 = 2'b01;
    localparam logic [1:0] OPER_ERET = 2'b10;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_HANDLER = 1'b1;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_EHBASE = 5'd25;

    logic [0:0]       state_r;
    logic             ie_r;
    logic             exl_r;
    logic             ip_r;
    logic [31:0]      epc_r;
    logic [31:0]      ehbase_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic [CNT_W-1:0] cnt_r;

    logic             rise_s;
    logic             mtc0_s;
    logic             take_s;
    logic             eret_s;

    // Event decode; take sees pre-write IE so a same-cycle MTC0 cannot enable itself
    always_comb begin
        rise_s = sync2_r & ~sync3_r;
        mtc0_s = en & (oper == OPER_MTC0);
        take_s = en & ir_en & ip_r & ie_r & ~exl_r & (cnt_r == CNT_ZERO) & (oper != OPER_ERET);
        eret_s = en & (oper == OPER_ERET) & (state_r == ST_HANDLER);
    end

    // Redirect and MFC0 read paths (no bypass of a same-cycle MTC0)
    always_comb begin
        jump_en = take_s | eret_s;
        if (take_s) begin
            jump_addr = ehbase_r;
        end else if (eret_s) begin
            jump_addr = epc_r;
        end else begin
            jump_addr = 32'h0000_0000;
        end
        case (addr_r)
            REG_STATUS: data_r = {30'd0, exl_r, ie_r};
            REG_CAUSE:  data_r = {21'd0, ip_r, 10'd0};
            REG_EPC:    data_r = epc_r;
            REG_EHBASE: data_r = ehbase_r;
            default:    data_r = 32'h0000_0000;
        endcase
    end

    // Two-flop synchroniser plus a third flop for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= ir_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Pending flag runs regardless of en; a fresh edge beats the clear on take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_r <= 1'b0;
        end else if (rise_s) begin
            ip_r <= 1'b1;
        end else if (take_s) begin
            ip_r <= 1'b0;
        end else begin
            ip_r <= ip_r;
        end
    end

    // Architectural registers, handler FSM and post-redirect holdoff counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            ie_r     <= 1'b0;
            exl_r    <= 1'b0;
            epc_r    <= 32'h0000_0000;
            ehbase_r <= HANDLER_ADDR;
            cnt_r    <= CNT_ZERO;
        end else begin
            if (mtc0_s && (addr_w == REG_STATUS)) begin
                ie_r <= data_w[0];
            end
            if (mtc0_s && (addr_w == REG_EHBASE)) begin
                ehbase_r <= {data_w[31:2], 2'b00};
            end
            if (take_s) begin
                state_r <= ST_HANDLER;
                exl_r   <= 1'b1;
                epc_r   <= ret_addr;
                cnt_r   <= HOLD_LOAD;
            end else if (eret_s) begin
                state_r <= ST_IDLE;
                exl_r   <= 1'b0;
                cnt_r   <= HOLD_LOAD;
            end else begin
                if (mtc0_s && (addr_w == REG_STATUS)) begin
                    exl_r <= data_w[1];
                end
                if (mtc0_s && (addr_w == REG_EPC)) begin
                    epc_r <= data_w;
                end
                if (en && (cnt_r != CNT_ZERO)) begin
                    cnt_r <= cnt_r - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scoreboard bench for cp0_ctrl: directed scenarios then randomized traffic, checked
// against a register-array reference model.
module tb_cp0_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [31:0] data_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [31:0] ret_addr;
    logic        ir_in;
    logic        jump_en;
    logic [31:0] jump_addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        je;
        logic [31:0] ja;
        logic [31:0] dr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state: a 32-entry register file view plus handler flag and holdoff
    logic [31:0] m_reg [32];
    bit          m_handler;
    int          m_hold;
    logic [2:0]  ir_hist;

    cp0_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .oper(oper), .addr_r(addr_r), .data_r(data_r),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ret_addr(ret_addr),
        .ir_in(ir_in), .jump_en(jump_en), .jump_addr(jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] wmask(input logic [4:0] a);
        case (a)
            5'd12:   return 32'h0000_0003;
            5'd14:   return 32'hFFFF_FFFF;
            5'd25:   return 32'hFFFF_FFFC;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic bit m_take();
        return en && ir_en && m_reg[13][10] && m_reg[12][0] && !m_reg[12][1]
               && (m_hold == 0) && (oper != 2'b10);
    endfunction

    function automatic bit m_eret();
        return en && (oper == 2'b10) && m_handler;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        m_reg[25] = 32'h0000_0100;
        m_handler = 1'b0;
        m_hold    = 0;
        ir_hist   = 3'b000;
    endtask

    // Advance the model across one rising edge using the inputs held during the last cycle
    task automatic model_step();
        bit tk, er, rise, ip;
        if (rst) begin
            model_reset();
        end else begin
            tk   = m_take();
            er   = m_eret();
            rise = ir_hist[1] & ~ir_hist[2];
            ip   = m_reg[13][10];
            if (rise) ip = 1'b1;
            else if (tk) ip = 1'b0;
            if (en && oper == 2'b01)
                m_reg[addr_w] = (m_reg[addr_w] & ~wmask(addr_w)) | (data_w & wmask(addr_w));
            if (tk) begin
                m_reg[14]    = ret_addr;
                m_reg[12][1] = 1'b1;
                m_handler    = 1'b1;
                m_hold       = 3;
            end else if (er) begin
                m_reg[12][1] = 1'b0;
                m_handler    = 1'b0;
                m_hold       = 3;
            end else if (en && m_hold > 0) begin
                m_hold = m_hold - 1;
            end
            m_reg[13] = ip ? 32'h0000_0400 : 32'h0;
            ir_hist   = {ir_hist[1:0], ir_in};
        end
    endtask

    task automatic tick(input logic t_rst, input logic t_en, input logic [1:0] t_oper,
                        input logic [4:0] t_ar, input logic [4:0] t_aw, input logic [31:0] t_dw,
                        input logic t_iren, input logic [31:0] t_ret, input logic t_ir);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        rst = t_rst; en = t_en; oper = t_oper; addr_r = t_ar; addr_w = t_aw;
        data_w = t_dw; ir_en = t_iren; ret_addr = t_ret; ir_in = t_ir;
        if (rst) model_reset();
        e.je = m_take() | m_eret();
        e.ja = m_take() ? m_reg[25] : (m_eret() ? m_reg[14] : 32'h0);
        e.dr = m_reg[t_ar];
        sb.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: pop one expectation per presented cycle and compare all outputs
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({jump_en, jump_addr, data_r} !== {mon_e.je, mon_e.ja, mon_e.dr}) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got je=%0b ja=%h dr=%h expected je=%0b ja=%h dr=%h",
                         $time, jump_en, jump_addr, data_r, mon_e.je, mon_e.ja, mon_e.dr);
            end
        end
    end

    function automatic logic [4:0] pick_addr();
        case ($urandom_range(0, 4))
            0:       return 5'd12;
            1:       return 5'd13;
            2:       return 5'd14;
            3:       return 5'd25;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic        r_ir;
        logic [4:0]  r_aw;
        logic [31:0] r_dw;
        rst = 1'b1; en = 1'b0; oper = 2'b00; addr_r = 5'd0; addr_w = 5'd0;
        data_w = 32'h0; ir_en = 1'b0; ret_addr = 32'h0; ir_in = 1'b0;
        model_reset();

        // Reset state
        tick(1, 0, 2'b00, 5'd25, 5'd0, 32'h0, 0, 32'h0, 0);
        chk("rst_jump_en", 32'(jump_en), 32'h0);
        chk("rst_jump_addr", jump_addr, 32'h0);
        chk("rst_ehbase", data_r, 32'h100);
        tick(1, 0, 2'b00, 5'd14, 5'd0, 32'h0, 0, 32'h0, 0);
        chk("rst_epc", data_r, 32'h0);

        // MTC0 STATUS then MFC0
        tick(0, 1, 2'b01, 5'd12, 5'd12, 32'h1, 0, 32'h0, 0);
        chk("mtc0_no_bypass", data_r, 32'h0);
        tick(0, 1, 2'b00, 5'd12, 5'd0, 32'h0, 0, 32'h0, 0);
        chk("status_after_write", data_r, 32'h1);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 0, 32'h0, 0);
        chk("cause_idle", data_r, 32'h0);

        // Interrupt pulse, 3-cycle sync latency, then take
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 0, 32'h40, 1);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 0, 32'h40, 0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 0, 32'h40, 0);
        chk("ip_before_latency", data_r, 32'h0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 0, 32'h40, 0);
        chk("ip_after_latency", data_r, 32'h400);
        tick(0, 1, 2'b00, 5'd12, 5'd0, 32'h0, 1, 32'h40, 0);
        chk("take_jump_en", 32'(jump_en), 32'h1);
        chk("take_jump_addr", jump_addr, 32'h100);
        tick(0, 1, 2'b00, 5'd14, 5'd0, 32'h0, 1, 32'h44, 1);
        chk("epc_after_take", data_r, 32'h40);
        tick(0, 1, 2'b00, 5'd12, 5'd0, 32'h0, 1, 32'h48, 0);
        chk("status_in_handler", data_r, 32'h3);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h4C, 0);
        chk("ip_cleared_by_take", data_r, 32'h0);

        // ERET with IP pending: ERET only, then holdoff with an en=0 freeze
        tick(0, 1, 2'b10, 5'd13, 5'd0, 32'h0, 1, 32'h50, 0);
        chk("eret_jump_en", 32'(jump_en), 32'h1);
        chk("eret_jump_addr", jump_addr, 32'h40);
        tick(0, 1, 2'b00, 5'd12, 5'd0, 32'h0, 1, 32'h54, 0);
        chk("exl_cleared", data_r, 32'h1);
        chk("holdoff_1", 32'(jump_en), 32'h0);
        tick(0, 0, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h58, 0);
        chk("frozen", 32'(jump_en), 32'h0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h5C, 0);
        chk("holdoff_2", 32'(jump_en), 32'h0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h60, 0);
        chk("holdoff_3", 32'(jump_en), 32'h0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h80, 0);
        chk("take_after_holdoff", 32'(jump_en), 32'h1);
        tick(0, 1, 2'b10, 5'd13, 5'd0, 32'h0, 0, 32'h0, 0);
        chk("eret2_addr", jump_addr, 32'h80);

        // IE=0 keeps IP pending; enabling IE takes one cycle after the write
        tick(0, 1, 2'b01, 5'd13, 5'd12, 32'h0, 1, 32'h90, 1);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h90, 0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h90, 0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'h90, 0);
        chk("ip_ie0", data_r, 32'h400);
        chk("no_take_ie0", 32'(jump_en), 32'h0);
        tick(0, 1, 2'b01, 5'd13, 5'd12, 32'h1, 1, 32'hB0, 0);
        chk("no_take_on_write", 32'(jump_en), 32'h0);
        tick(0, 1, 2'b00, 5'd13, 5'd0, 32'h0, 1, 32'hC0, 0);
        chk("take_after_write", 32'(jump_en), 32'h1);

        // Reset while in handler
        tick(1, 1, 2'b10, 5'd25, 5'd0, 32'h0, 1, 32'h0, 0);
        chk("rst_mid_jump", 32'(jump_en), 32'h0);
        chk("rst_mid_ehbase", data_r, 32'h100);
        tick(1, 1, 2'b00, 5'd14, 5'd0, 32'h0, 1, 32'h0, 0);
        chk("rst_mid_epc", data_r, 32'h0);
        tick(0, 1, 2'b10, 5'd13, 5'd0, 32'h0, 1, 32'h0, 0);
        chk("eret_in_idle", 32'(jump_en), 32'h0);
        chk("ip_lost", data_r, 32'h0);

        // Randomized traffic
        r_ir = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) r_ir = ~r_ir;
            r_aw = pick_addr();
            r_dw = $urandom;
            if (r_aw == 5'd12) r_dw[1] = ($urandom_range(0, 3) == 0);
            tick(($urandom_range(0, 255) == 0), ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), pick_addr(), r_aw, r_dw,
                 ($urandom_range(0, 3) != 0), $urandom, r_ir);
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
